// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the
// per-line sprite scan-and-fetch controller.
package sprite_pkg;

  localparam int NUM_OAM = 40;
  localparam int MAX_LINE = 10;

  localparam logic [12:0] SPRITE_BASE = 13'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FETCH_LO,
    S_FETCH_HI,
    S_DONE
  } state_t;

endpackage

// File: rtl/sprite_list.sv
// Small index buffer of visible sprites for one line.
// Ports: clk, reset, clr, push, din (6b), rd_idx (4b), dout (6b).
module sprite_list
  import sprite_pkg::*;
#(
  parameter int DEPTH = MAX_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       push,
  input  logic [5:0] din,
  input  logic [3:0] rd_idx,
  output logic [5:0] dout
);

  logic [5:0] mem [DEPTH];
  logic [3:0] wp;
  logic       wr;

  // Clear wins over a simultaneous append.
  assign wr = push && !clr && (wp < 4'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wp <= '0;
    end else if (wr) begin
      wp <= wp + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mem[wp] <= din;
    end
  end

  assign dout = (rd_idx < 4'(DEPTH)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/sprite_fetcher.sv
// Per-line sprite scan (first visible slots) and VRAM tile-row fetch.
// Ports: clk, reset, line_start, obj_en, sel/sel_x/sel_addr, vram_*, ds, busy, count.
module sprite_fetcher
  import sprite_pkg::*;
#(
  parameter int NUM_OAM = sprite_pkg::NUM_OAM,
  parameter int MAX_LINE = sprite_pkg::MAX_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic        obj_en,
  output logic [5:0]  sel,
  input  logic [7:0]  sel_x,
  input  logic [10:0] sel_addr,
  output logic        vram_req,
  output logic [12:0] vram_addr,
  input  logic        vram_ack,
  output logic [1:0]  ds,
  output logic        busy,
  output logic [3:0]  count
);

  state_t     state, state_n;
  logic [5:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] ptr, ptr_n;
  logic [3:0] cnt_inc;
  logic       hit;
  logic       push;
  logic       clr;
  logic       plane;
  logic       last_slot;
  logic       full;
  logic [5:0] list_q;

  sprite_list #(
    .DEPTH(MAX_LINE)
  ) u_list (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push),
    .din   (idx),
    .rd_idx(ptr),
    .dout  (list_q)
  );

  assign hit = (sel_x != 8'hff);
  assign cnt_inc = cnt + 4'd1;
  assign last_slot = (idx == 6'(NUM_OAM - 1));
  // Stop as soon as this slot fills the list.
  assign full = hit && (cnt_inc == 4'(MAX_LINE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    ptr_n = ptr;
    push = 1'b0;
    clr = 1'b0;
    if (line_start) begin
      clr = 1'b1;
      idx_n = '0;
      cnt_n = '0;
      ptr_n = '0;
      state_n = obj_en ? S_SCAN : S_DONE;
    end else begin
      unique case (state)
        S_SCAN: begin
          push = hit;
          if (hit) begin
            cnt_n = cnt_inc;
          end
          idx_n = idx + 6'd1;
          if (last_slot || full) begin
            ptr_n = '0;
            state_n = (cnt_n == 4'd0) ? S_DONE : S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          if (vram_ack) begin
            state_n = S_FETCH_HI;
          end
        end
        S_FETCH_HI: begin
          if (vram_ack) begin
            if (ptr == cnt - 4'd1) begin
              state_n = S_DONE;
            end else begin
              ptr_n = ptr + 4'd1;
              state_n = S_FETCH_LO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign vram_req = (state == S_FETCH_LO) || (state == S_FETCH_HI);
  assign plane = (state == S_FETCH_HI);
  assign busy = (state == S_SCAN) || vram_req;
  assign count = cnt;

  assign sel = (state == S_SCAN) ? idx :
               vram_req ? list_q : 6'd0;

  assign vram_addr = vram_req ?
    (SPRITE_BASE | {1'b0, sel_addr, plane}) : 13'd0;

  assign ds = {vram_ack && (state == S_FETCH_HI),
               vram_ack && (state == S_FETCH_LO)};

endmodule

// File: tb/tb_sprite_fetcher.sv
// Directed bench for sprite_fetcher with a slot table and
// a VRAM responder of configurable latency.
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic        obj_en;
  logic [5:0]  sel;
  logic [7:0]  sel_x;
  logic [10:0] sel_addr;
  logic        vram_req;
  logic [12:0] vram_addr;
  logic        vram_ack;
  logic [1:0]  ds;
  logic        busy;
  logic [3:0]  count;

  logic [7:0]  slot_x [40];
  logic [10:0] slot_addr [40];

  int n_run = 0;
  int n_fail = 0;

  int n_ds, n_ack, req_cyc, scan_cyc, first_req, idle_gap;
  bit busy_seen, unstable, ds11, done;
  logic [3:0]  end_count;
  logic [1:0]  ds_log [32];
  logic [5:0]  sel_log [32];
  logic [12:0] addr_log [32];

  sprite_fetcher dut (
    .clk       (clk),
    .reset     (reset),
    .line_start(line_start),
    .obj_en    (obj_en),
    .sel       (sel),
    .sel_x     (sel_x),
    .sel_addr  (sel_addr),
    .vram_req  (vram_req),
    .vram_addr (vram_addr),
    .vram_ack  (vram_ack),
    .ds        (ds),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  assign sel_x = (sel < 6'd40) ? slot_x[sel] : 8'hff;
  assign sel_addr = (sel < 6'd40) ? slot_addr[sel] : 11'h000;

  task automatic set_slots(input logic [39:0] mask);
    for (int i = 0; i < 40; i++) begin
      slot_x[i] = mask[i] ? 8'(i + 1) : 8'hff;
      slot_addr[i] = 11'(i * 53 + 17);
    end
  endtask

  // Pulses line_start (optionally), then answers VRAM requests
  // until busy drops, stop_ds strobes are seen, or the budget ends.
  task automatic run_line(input int lat, input int stop_ds,
                          input bit pulse);
    int w;
    int last_ack;
    logic [5:0] s0;
    logic [12:0] a0;
    w = 0;
    last_ack = -10;
    n_ds = 0;
    n_ack = 0;
    req_cyc = 0;
    scan_cyc = 0;
    first_req = -1;
    idle_gap = -1;
    busy_seen = 0;
    unstable = 0;
    ds11 = 0;
    done = 0;
    end_count = 4'hx;
    s0 = '0;
    a0 = '0;
    if (pulse) begin
      @(posedge clk); #1;
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      vram_ack = 1'b0;
      if (!busy) begin
        done = 1;
        idle_gap = c - last_ack;
        end_count = count;
        break;
      end
      busy_seen = 1;
      if (vram_req) begin
        req_cyc++;
        if (first_req < 0) first_req = c;
        w++;
        if (w == 1) begin
          s0 = sel;
          a0 = vram_addr;
        end else if (sel !== s0 || vram_addr !== a0) begin
          unstable = 1;
        end
      end else begin
        w = 0;
        scan_cyc++;
      end
      vram_ack = vram_req && (w > lat);
      #1;
      if (ds === 2'b11) ds11 = 1;
      if (ds !== 2'b00) begin
        if (n_ds < 32) begin
          ds_log[n_ds] = ds;
          sel_log[n_ds] = sel;
          addr_log[n_ds] = vram_addr;
        end
        n_ds++;
      end
      if (vram_ack) begin
        w = 0;
        n_ack++;
        last_ack = c;
      end
      if (stop_ds != 0 && n_ds == stop_ds) begin
        @(posedge clk); #1;
        vram_ack = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    vram_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    line_start = 1'b1;
    obj_en = 1'b1;
    vram_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (sel !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_sel: got %0d want 0", sel);
    end
    n_run++;
    if (vram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got %b want 0", vram_req);
    end
    n_run++;
    if (vram_addr !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", vram_addr);
    end
    n_run++;
    if (ds !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ds: got %b want 00", ds);
    end
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_run++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    reset = 1'b0;
    line_start = 1'b0;
    vram_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_three(input string tag);
    int es [3];
    logic [5:0] s;
    es = '{3, 7, 20};
    n_run++;
    if (!done || end_count !== 4'd3) begin
      n_fail++;
      $display("FAIL %s_count: got %0d done=%0d want 3", tag, end_count, done);
    end
    n_run++;
    if (n_ds !== 6 || ds11) begin
      n_fail++;
      $display("FAIL %s_nds: got %0d ds11=%0d want 6", tag, n_ds, ds11);
    end
    for (int k = 0; k < 6 && k < n_ds; k++) begin
      s = 6'(es[k / 2]);
      n_run++;
      if (ds_log[k] !== ((k % 2) ? 2'b10 : 2'b01) || sel_log[k] !== s ||
          addr_log[k] !== {1'b0, slot_addr[s], 1'(k % 2)}) begin
        n_fail++;
        $display("FAIL %s_strobe%0d: got ds=%b sel=%0d addr=%h want sel=%0d addr=%h",
                 tag, k, ds_log[k], sel_log[k], addr_log[k], s,
                 {1'b0, slot_addr[s], 1'(k % 2)});
      end
    end
    n_run++;
    if (unstable) begin
      n_fail++;
      $display("FAIL %s_stable: got sel/addr change while req high want none", tag);
    end
  endtask

  task automatic test_three;
    set_slots(40'h0000100088);
    obj_en = 1'b1;
    run_line(1, 0, 1);
    check_three("three");
    n_run++;
    if (scan_cyc !== 40 || first_req !== 40) begin
      n_fail++;
      $display("FAIL three_scan: got scan=%0d first_req=%0d want 40/40",
               scan_cyc, first_req);
    end
    n_run++;
    if (req_cyc !== 12) begin
      n_fail++;
      $display("FAIL three_req_cycles: got %0d want 12", req_cyc);
    end
    n_run++;
    if (idle_gap !== 1) begin
      n_fail++;
      $display("FAIL three_busy_fall: got gap %0d want 1", idle_gap);
    end
  endtask

  task automatic test_all_visible;
    set_slots({40{1'b1}});
    obj_en = 1'b1;
    run_line(1, 0, 1);
    n_run++;
    if (!done || end_count !== 4'd10) begin
      n_fail++;
      $display("FAIL all_count: got %0d want 10", end_count);
    end
    n_run++;
    if (scan_cyc !== 10) begin
      n_fail++;
      $display("FAIL all_scan: got %0d cycles want 10", scan_cyc);
    end
    n_run++;
    if (req_cyc !== 40 || n_ds !== 20) begin
      n_fail++;
      $display("FAIL all_fetch: got req=%0d nds=%0d want 40/20", req_cyc, n_ds);
    end
    for (int k = 0; k < 20 && k < n_ds; k++) begin
      n_run++;
      if (sel_log[k] !== 6'(k / 2)) begin
        n_fail++;
        $display("FAIL all_order%0d: got sel=%0d want %0d", k, sel_log[k], k / 2);
      end
    end
  endtask

  task automatic test_obj_disabled;
    set_slots({40{1'b1}});
    obj_en = 1'b0;
    run_line(1, 0, 1);
    n_run++;
    if (busy_seen || n_ds !== 0) begin
      n_fail++;
      $display("FAIL objdis_idle: got busy_seen=%0d nds=%0d want 0/0",
               busy_seen, n_ds);
    end
    n_run++;
    if (end_count !== 4'd0) begin
      n_fail++;
      $display("FAIL objdis_count: got %0d want 0", end_count);
    end
    vram_ack = 1'b1;
    #1;
    n_run++;
    if (ds !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_ack: got ds=%b want 00", ds);
    end
    @(posedge clk); #1;
    vram_ack = 1'b0;
    obj_en = 1'b1;
  endtask

  task automatic test_none;
    set_slots(40'h0);
    run_line(1, 0, 1);
    n_run++;
    if (!done || end_count !== 4'd0) begin
      n_fail++;
      $display("FAIL none_count: got %0d want 0", end_count);
    end
    n_run++;
    if (scan_cyc !== 40) begin
      n_fail++;
      $display("FAIL none_scan: got %0d cycles want 40", scan_cyc);
    end
    n_run++;
    if (req_cyc !== 0 || n_ds !== 0) begin
      n_fail++;
      $display("FAIL none_req: got req=%0d nds=%0d want 0/0", req_cyc, n_ds);
    end
  endtask

  task automatic test_stall;
    set_slots(40'h0000100088);
    run_line(5, 0, 1);
    check_three("stall");
    n_run++;
    if (req_cyc !== 36 || n_ack !== n_ds) begin
      n_fail++;
      $display("FAIL stall_cycles: got req=%0d acks=%0d nds=%0d want 36/6/6",
               req_cyc, n_ack, n_ds);
    end
  endtask

  task automatic test_abort;
    set_slots(40'h0000100088);
    run_line(1, 3, 1);
    n_run++;
    if (vram_req !== 1'b1 || sel !== 6'd7 || vram_addr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got req=%b sel=%0d plane=%b want 1/7/1",
               vram_req, sel, vram_addr[0]);
    end
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    n_run++;
    if (count !== 4'd0 || busy !== 1'b1 || vram_req !== 1'b0 || sel !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_restart: got count=%0d busy=%b req=%b sel=%0d want 0/1/0/0",
               count, busy, vram_req, sel);
    end
    run_line(1, 0, 0);
    check_three("abort");
  endtask

  task automatic test_reset_mid;
    set_slots(40'h0000100088);
    @(posedge clk); #1;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_run++;
    if (count !== 4'd2 || sel !== 6'd10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan: got count=%0d sel=%0d busy=%b want 2/10/1",
               count, sel, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (sel !== 6'd0 || busy !== 1'b0 || vram_req !== 1'b0 ||
        vram_addr !== 13'd0 || count !== 4'd0 || ds !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: got sel=%0d busy=%b req=%b addr=%h count=%0d ds=%b want zeros",
               sel, busy, vram_req, vram_addr, count, ds);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    set_slots(40'h0);
    test_reset();
    test_three();
    test_all_visible();
    test_obj_disabled();
    test_none();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
